coincidence_capture: RTL and testbench

COINCIDENCE_CAPTURE -- requirements
Module: coincidence_capture

---
 rtl/coincidence_capture_if.sv | 29 ++
 rtl/coincidence_capture.sv | 145 ++++++++++++++
 tb/tb_coincidence_capture.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/coincidence_capture_if.sv
// Report channel of coincidence_capture: valid/ready handshake carrying the
// captured data word, start timestamp and overlap length.
interface coincidence_capture_if #(
    parameter int DATA_W  = 2,
    parameter int LEN_W   = 8,
    parameter int STAMP_W = 16
);
    logic               cap_valid;
    logic               cap_ready;
    logic [DATA_W-1:0]  cap_data;
    logic [STAMP_W-1:0] cap_stamp;
    logic [LEN_W-1:0]   cap_len;

    modport master (
        output cap_valid,
        output cap_data,
        output cap_stamp,
        output cap_len,
        input  cap_ready
    );

    modport slave (
        input  cap_valid,
        input  cap_data,
        input  cap_stamp,
        input  cap_len,
        output cap_ready
    );
endinterface

// File: rtl/coincidence_capture.sv
// Detects overlaps of two strobes, timestamps and measures each overlap, and
// offers one report at a time over a valid/ready channel; overlaps starting
// while a report is unconsumed are counted and flagged as overrun.
module coincidence_capture #(
    parameter int DATA_W  = 2,
    parameter int LEN_W   = 8,
    parameter int STAMP_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              d_strb,
    input  logic              f_strb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_overrun,
    coincidence_capture_if.master cap,
    output logic [LEN_W-1:0]  event_cnt,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        REPORT = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic               prev_r;
    logic [STAMP_W-1:0] ts_r;
    logic               valid_r, valid_s;
    logic [DATA_W-1:0]  data_r, data_s;
    logic [STAMP_W-1:0] stamp_r, stamp_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [LEN_W-1:0]   cnt_r;
    logic               overrun_r;
    logic               overlap_s;
    logic               start_s;
    logic               overrun_set_s;

    assign overlap_s = d_strb & f_strb;
    assign start_s   = overlap_s & ~prev_r;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next report contents
    always_comb begin
        state_s       = state_r;
        valid_s       = valid_r;
        data_s        = data_r;
        stamp_s       = stamp_r;
        len_s         = len_r;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = ACTIVE;
                    data_s  = data_in;
                    stamp_s = ts_r;
                    len_s   = LEN_W'(1'b1);
                end else begin
                    state_s = IDLE;
                end
            end
            ACTIVE: begin
                if (overlap_s) begin
                    if (len_r != {LEN_W{1'b1}}) begin
                        len_s = len_r + LEN_W'(1'b1);
                    end else begin
                        len_s = len_r;
                    end
                end else begin
                    state_s = REPORT;
                    valid_s = 1'b1;
                end
            end
            REPORT: begin
                if (cap.cap_ready) begin
                    valid_s = 1'b0;
                    if (start_s) begin
                        state_s = ACTIVE;
                        data_s  = data_in;
                        stamp_s = ts_r;
                        len_s   = LEN_W'(1'b1);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    // Pending report wins; the new overlap is only counted
                    overrun_set_s = start_s;
                end
            end
            default: begin
                state_s = IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // Report registers, timestamp, overlap history, event counter, overrun
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r   <= 1'b0;
            data_r    <= '0;
            stamp_r   <= '0;
            len_r     <= '0;
            ts_r      <= '0;
            prev_r    <= 1'b0;
            cnt_r     <= '0;
            overrun_r <= 1'b0;
        end else begin
            valid_r <= valid_s;
            data_r  <= data_s;
            stamp_r <= stamp_s;
            len_r   <= len_s;
            ts_r    <= ts_r + STAMP_W'(1'b1);
            prev_r  <= overlap_s;
            if (start_s && (cnt_r != {LEN_W{1'b1}})) begin
                cnt_r <= cnt_r + LEN_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign cap.cap_valid = valid_r;
    assign cap.cap_data  = data_r;
    assign cap.cap_stamp = stamp_r;
    assign cap.cap_len   = len_r;
    assign event_cnt     = cnt_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_coincidence_capture.sv
// Directed bench for coincidence_capture: edge k after reset release samples
// the inputs set up for cycle k, and the timestamp value seen at edge k is k.
module tb_coincidence_capture;

    logic       clock;
    logic       reset_n;
    logic       d_strb;
    logic       f_strb;
    logic [1:0] data_in;
    logic       clr_overrun;
    logic [7:0] event_cnt;
    logic       overrun;
    int         checks;
    int         failures;

    coincidence_capture_if #(.DATA_W(2), .LEN_W(8), .STAMP_W(16)) cap_bus ();

    coincidence_capture #(.DATA_W(2), .LEN_W(8), .STAMP_W(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .d_strb      (d_strb),
        .f_strb      (f_strb),
        .data_in     (data_in),
        .clr_overrun (clr_overrun),
        .cap         (cap_bus.master),
        .event_cnt   (event_cnt),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic d, input logic f, input logic [1:0] dat,
                         input logic rdy, input logic clr);
        d_strb            = d;
        f_strb            = f;
        data_in           = dat;
        cap_bus.cap_ready = rdy;
        clr_overrun       = clr;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},   32'(cap_bus.cap_valid), 32'd0);
        chk({tag, "_data"},    32'(cap_bus.cap_data),  32'd0);
        chk({tag, "_stamp"},   32'(cap_bus.cap_stamp), 32'd0);
        chk({tag, "_len"},     32'(cap_bus.cap_len),   32'd0);
        chk({tag, "_cnt"},     32'(event_cnt),         32'd0);
        chk({tag, "_overrun"}, 32'(overrun),           32'd0);
    endtask

    // Assert reset asynchronously, hold two edges, release just after an edge
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_all_zero("rst");
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic check_report(input string tag, input logic [1:0] dat,
                                input logic [15:0] stamp, input logic [7:0] len,
                                input logic [7:0] cnt);
        chk({tag, "_valid"}, 32'(cap_bus.cap_valid), 32'd1);
        chk({tag, "_data"},  32'(cap_bus.cap_data),  32'(dat));
        chk({tag, "_stamp"}, 32'(cap_bus.cap_stamp), 32'(stamp));
        chk({tag, "_len"},   32'(cap_bus.cap_len),   32'(len));
        chk({tag, "_cnt"},   32'(event_cnt),         32'(cnt));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();

        // Basic capture: d high 10-15, f high 12-13
        do_reset();
        for (int k = 0; k <= 15; k++) begin
            drive((k >= 10) && (k <= 15), (k >= 12) && (k <= 13),
                  (k == 12) ? 2'b01 : 2'b10, 1'b0, 1'b0);
            tick();
            if (k == 13) chk("basic_latency", 32'(cap_bus.cap_valid), 32'd0);
            if (k == 14) check_report("basic", 2'b01, 16'd12, 8'd2, 8'd1);
        end
        check_report("basic_hold", 2'b01, 16'd12, 8'd2, 8'd1);
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        chk("basic_accept", 32'(cap_bus.cap_valid), 32'd0);
        chk("basic_overrun", 32'(overrun), 32'd0);

        // Strobes never coincident
        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive(k >= 3, k <= 2, 2'b11, 1'b0, 1'b0);
            tick();
        end
        chk("nocoin_valid", 32'(cap_bus.cap_valid), 32'd0);
        chk("nocoin_cnt", 32'(event_cnt), 32'd0);

        // Long overlap saturates the length field
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b1, (k == 0) ? 2'b10 : 2'b01, 1'b0, 1'b0);
            tick();
            if (k == 1) chk("sat_len_mid", 32'(cap_bus.cap_len), 32'd2);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check_report("sat", 2'b10, 16'd0, 8'd255, 8'd1);

        // Overrun: second overlap dropped while report pending
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            drive((k <= 1) || (k == 7) || (k == 8), (k <= 1) || (k == 7) || (k == 8),
                  (k == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0);
            tick();
            if (k == 2) check_report("ovr_first", 2'b11, 16'd0, 8'd2, 8'd1);
            if (k == 2) chk("ovr_clear_before", 32'(overrun), 32'd0);
        end
        check_report("ovr_kept", 2'b11, 16'd0, 8'd2, 8'd2);
        chk("ovr_set", 32'(overrun), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        chk("ovr_clr", 32'(overrun), 32'd0);
        // Edge 11: clear and a new dropped start together, set wins
        drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        tick();
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        chk("ovr_cnt3", 32'(event_cnt), 32'd3);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        tick();
        chk("ovr_clr2", 32'(overrun), 32'd0);

        // Edge 13: accept and new start in the same cycle
        drive(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        tick();
        chk("acc_valid_low", 32'(cap_bus.cap_valid), 32'd0);
        chk("acc_data", 32'(cap_bus.cap_data), 32'd2);
        chk("acc_stamp", 32'(cap_bus.cap_stamp), 32'd13);
        chk("acc_overrun", 32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check_report("single", 2'b10, 16'd13, 8'd1, 8'd4);
        // Edge 15: back-to-back event after one low cycle, accepted at once
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check_report("b2b", 2'b01, 16'd15, 8'd1, 8'd5);
        chk("b2b_overrun", 32'(overrun), 32'd0);

        // Reset during ACTIVE with strobes held high
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
            tick();
        end
        do_reset();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check_report("rst_restart", 2'b01, 16'd0, 8'd2, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
